inst_fetch: RTL

Instruction fetch unit: owns the program counter, issues word reads to instruction memory, buffers returned instructions in a small in-order prefetch FIFO and presents them with their PC to the single-cycle datapath's `inst` input. Supports a single-cycle redirect (branch/jump target) that flushes buffered and in-flight fetches. Sits between instruction memory and the datapath; the datapath consumes one instruction per accepted `inst_ready`.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/inst_fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch slice: data widths, architectural constants
// and the {pc, inst} record carried through the prefetch buffer.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// In-order prefetch buffer of {pc, inst} entries. Implemented as a shift
// register with the head always in slot 0, so the head fields come straight
// from flops. Vacated slots are refilled with a NOP so the head instruction
// reads as NOP whenever the buffer is empty. Flush dominates push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_after_pop;

    // Next contents: flush clears, otherwise pop shifts first and push lands
    // in the first free slot left after the pop.
    always_comb begin
        mem_d           = mem_q;
        count_d         = count_q;
        count_after_pop = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].inst = NOP_INST;
            end
            count_d = '0;
        end else begin
            if (pop && (count_q != '0)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                mem_d[DEPTH-1].inst = NOP_INST;
                count_after_pop     = count_q - ONE;
            end
            count_d = count_after_pop;
            if (push && (count_after_pop < DEPTH_C)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count_after_pop) begin
                        mem_d[i] = push_data;
                    end
                end
                count_d = count_after_pop + ONE;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: RESET_PC, inst: NOP_INST};
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head  = mem_q[0];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads to instruction
// memory under a credit limit (outstanding + buffered <= DEPTH), tags
// returned words with their PC into the prefetch buffer, and drops responses
// that were in flight when a redirect arrived.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   rsp_dec;
    logic [CW-1:0]   req_inc;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_fire;
    logic            push_fire;
    logic            pop_fire;

    // Credit uses registered occupancy only, so a pop frees its slot for a
    // new request one cycle later. A response with nothing outstanding is a
    // protocol violation and is ignored entirely.
    assign credit_ok      = ({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_W;
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (out_q != '0);
    assign push_fire      = rsp_fire && (drop_q == '0) && !redirect_valid;
    assign inst_valid     = (fifo_count != '0);
    assign pop_fire       = inst_valid && inst_ready && !redirect_valid;
    assign rsp_dec        = rsp_fire ? ONE : '0;
    assign req_inc        = req_fire ? ONE : '0;
    assign push_entry     = '{pc: rsp_pc_q, inst: imem_rsp_data};

    // PC, response PC, outstanding and drop counters; redirect wins over
    // everything except reset and marks every still-outstanding read stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else if (redirect_valid) begin
            pc_q     <= align_word(redirect_pc);
            rsp_pc_q <= align_word(redirect_pc);
            out_q    <= out_q - rsp_dec;
            drop_q   <= out_q - rsp_dec;
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (push_fire) begin
                rsp_pc_q <= rsp_pc_q + PC_STEP;
            end
            out_q <= out_q + req_inc - rsp_dec;
            if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - ONE;
            end
        end
    end

    fetch_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_fire),
        .push_data (push_entry),
        .pop       (pop_fire),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign imem_addr = pc_q;
    assign inst      = head.inst;
    assign inst_pc   = head.pc;

endmodule
